int_reg_scoreboard: RTL

Issue-side hazard controller for the 32-entry integer architectural register file. It tracks in-flight writes per register and gates the scheduler's issue into register fetch. An instruction issues only if none of its sources has an outstanding write and its destination has not hit the in-flight limit. Writeback retires entries; flush clears state and holds issue for a fixed recovery window.

---
 rtl/int_reg_scoreboard.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/int_reg_scoreboard.sv
// Issue-side hazard controller for the integer register file.
// Counts outstanding writes per architectural register, blocks issue on
// read-after-write and per-register write-limit hazards, retires counts on
// writeback, and holds issue for a short recovery window after a flush.

module int_reg_scoreboard #(
   parameter int NUM_REGS     = 32,
   parameter int MAX_INFLIGHT = 3,
   parameter int HOLD_CYCLES  = 2
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic                        i_flush,
   input  logic                        i_stall,
   input  logic                        i_issue_valid,
   input  logic                        i_rs1_valid,
   input  logic [$clog2(NUM_REGS)-1:0] i_rs1_idx,
   input  logic                        i_rs2_valid,
   input  logic [$clog2(NUM_REGS)-1:0] i_rs2_idx,
   input  logic                        i_rd_valid,
   input  logic [$clog2(NUM_REGS)-1:0] i_rd_idx,
   output logic                        o_issue_ready,
   input  logic                        i_wb_valid,
   input  logic [$clog2(NUM_REGS)-1:0] i_wb_idx,
   output logic [NUM_REGS-1:0]         o_busy_mask,
   output logic [6:0]                  o_inflight,
   output logic                        o_holding
);

   localparam int IW = $clog2(NUM_REGS);
   localparam int CW = $clog2(MAX_INFLIGHT + 1);
   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX   = CW'(MAX_INFLIGHT);
   localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

   typedef enum logic {
      RUN  = 1'b0,
      HOLD = 1'b1
   } stateT;

   stateT              state;
   logic [HW-1:0]      holdCnt;
   logic [CW-1:0]      cnt [NUM_REGS];
   logic [6:0]         inflight;

   logic               rs1Hazard;
   logic               rs2Hazard;
   logic               rawHazard;
   logic               structHazard;
   logic               fire;
   logic               incEn;
   logic               decEn;
   logic [NUM_REGS-1:0] incVec;
   logic [NUM_REGS-1:0] decVec;

   // Hazard detection looks only at the registered counters, so a writeback
   // in this cycle cannot unblock a dependent instruction until the next one.
   // Register 0 is never a hazard. Issue readiness is independent of
   // i_issue_valid so the scheduler can use it to pick an instruction.
   always_comb begin
      rs1Hazard     = i_rs1_valid && (i_rs1_idx != '0) && (cnt[i_rs1_idx] != '0);
      rs2Hazard     = i_rs2_valid && (i_rs2_idx != '0) && (cnt[i_rs2_idx] != '0);
      rawHazard     = rs1Hazard || rs2Hazard;
      structHazard  = i_rd_valid && (i_rd_idx != '0) && (cnt[i_rd_idx] == CNT_MAX);
      o_issue_ready = (state == RUN) && !i_stall && !rawHazard && !structHazard
                      && !i_flush && !i_rst;
      fire          = i_issue_valid && o_issue_ready;
      incEn         = fire && i_rd_valid && (i_rd_idx != '0);
      decEn         = i_wb_valid && (i_wb_idx != '0) && (cnt[i_wb_idx] != '0);
   end

   // One-hot increment and decrement selects per register; a decrement is
   // only ever raised for a nonzero counter, so counters cannot underflow.
   always_comb begin
      incVec = '0;
      decVec = '0;
      if (incEn) begin
         incVec[i_rd_idx] = 1'b1;
      end
      if (decEn) begin
         decVec[i_wb_idx] = 1'b1;
      end
   end

   // Per-register in-flight write counters. An issue and a writeback that
   // land on the same register in one cycle cancel out. Reset and flush
   // both clear everything, and flush discards that cycle's issue and WB.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_flush) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            cnt[r] <= '0;
         end
      end else begin
         for (int r = 0; r < NUM_REGS; r++) begin
            if (incVec[r] && !decVec[r]) begin
               cnt[r] <= cnt[r] + CW'(1);
            end else if (decVec[r] && !incVec[r]) begin
               cnt[r] <= cnt[r] - CW'(1);
            end
         end
      end
   end

   // Total outstanding writes across all registers, saturating at the top
   // of its range and following the same cancel-out rule as the counters.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_flush) begin
         inflight <= '0;
      end else if (incEn && !decEn && (inflight != 7'h7F)) begin
         inflight <= inflight + 7'd1;
      end else if (decEn && !incEn && (inflight != 7'd0)) begin
         inflight <= inflight - 7'd1;
      end
   end

   // Flush recovery FSM: a flush (also one arriving mid-hold) loads the hold
   // counter, and issue stays blocked until it has counted down through zero.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state   <= RUN;
         holdCnt <= '0;
      end else if (i_flush) begin
         state   <= HOLD;
         holdCnt <= HOLD_LOAD;
      end else begin
         case (state)
            RUN: begin
               holdCnt <= '0;
            end
            HOLD: begin
               if (holdCnt == '0) begin
                  state <= RUN;
               end else begin
                  holdCnt <= holdCnt - HW'(1);
               end
            end
            default: begin
               state   <= RUN;
               holdCnt <= '0;
            end
         endcase
      end
   end

   // Status outputs come straight from registered state; register 0 is
   // never reported busy.
   always_comb begin
      o_busy_mask = '0;
      for (int r = 1; r < NUM_REGS; r++) begin
         o_busy_mask[r] = (cnt[r] != '0);
      end
      o_inflight = inflight;
      o_holding  = (state == HOLD);
   end

endmodule
